// File: rtl/gray_port_arbiter_if.sv
// rtl/gray_port_arbiter_if.sv - client and gray-memory read-port signals of the arbiter
interface gray_port_arbiter_if;
    logic        c0_req;
    logic        c1_req;
    logic [13:0] c0_addr;
    logic [13:0] c1_addr;
    logic        c0_lock;
    logic        c1_lock;
    logic        c0_gnt;
    logic        c1_gnt;
    logic        c0_rvalid;
    logic        c1_rvalid;
    logic [7:0]  c0_rdata;
    logic [7:0]  c1_rdata;
    logic [13:0] gray_addr;
    logic        gray_req;
    logic        gray_ready;
    logic [7:0]  gray_data;
    logic        busy;

    modport master (
        input  c0_req, c1_req, c0_addr, c1_addr, c0_lock, c1_lock,
        input  gray_ready, gray_data,
        output c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
        output gray_addr, gray_req, busy
    );

    modport slave (
        output c0_req, c1_req, c0_addr, c1_addr, c0_lock, c1_lock,
        output gray_ready, gray_data,
        input  c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
        input  gray_addr, gray_req, busy
    );
endinterface

// File: rtl/gray_port_arbiter.sv
// rtl/gray_port_arbiter.sv - two-client round-robin arbiter with burst lock for the gray memory read port
module gray_port_arbiter #(
    parameter int MAX_BURST = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    gray_port_arbiter_if.master  bus
);
    logic        gray_req_q, gray_req_d;
    logic [13:0] gray_addr_q, gray_addr_d;
    logic        tag_q, tag_d;
    logic        rv_pipe_q, rv_pipe_d;
    logic        rtag_pipe_q, rtag_pipe_d;
    logic        c0_rvalid_q, c0_rvalid_d;
    logic        c1_rvalid_q, c1_rvalid_d;
    logic [7:0]  c0_rdata_q, c0_rdata_d;
    logic [7:0]  c1_rdata_q, c1_rdata_d;
    logic        owner_q, owner_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;

    logic slot_free;
    logic owner_lock;
    logic winner;
    logic grant;

    always_comb begin
        slot_free  = !gray_req_q || bus.gray_ready;
        owner_lock = owner_q ? bus.c1_lock : bus.c0_lock;
        // Under contention the owner keeps the port only while locked and below the burst limit.
        if (bus.c0_req && bus.c1_req) begin
            winner = (owner_lock && (32'(burst_cnt_q) < MAX_BURST)) ? owner_q : !owner_q;
        end else begin
            winner = bus.c1_req && !bus.c0_req;
        end
        grant = slot_free && (bus.c0_req || bus.c1_req) && !reset;

        gray_req_d  = gray_req_q;
        gray_addr_d = gray_addr_q;
        tag_d       = tag_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        if (grant) begin
            gray_req_d  = 1'b1;
            gray_addr_d = winner ? bus.c1_addr : bus.c0_addr;
            tag_d       = winner;
            if (winner == owner_q) begin
                burst_cnt_d = (burst_cnt_q == 4'd15) ? 4'd15 : burst_cnt_q + 4'd1;
            end else begin
                owner_d     = winner;
                burst_cnt_d = 4'd1;
            end
        end else if (slot_free) begin
            gray_req_d = 1'b0;
        end

        rv_pipe_d   = gray_req_q && bus.gray_ready;
        rtag_pipe_d = rv_pipe_d ? tag_q : rtag_pipe_q;

        c0_rvalid_d = rv_pipe_q && !rtag_pipe_q;
        c1_rvalid_d = rv_pipe_q && rtag_pipe_q;
        c0_rdata_d  = c0_rvalid_d ? bus.gray_data : c0_rdata_q;
        c1_rdata_d  = c1_rvalid_d ? bus.gray_data : c1_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gray_req_q  <= 1'b0;
            gray_addr_q <= 14'd0;
            tag_q       <= 1'b0;
            rv_pipe_q   <= 1'b0;
            rtag_pipe_q <= 1'b0;
            c0_rvalid_q <= 1'b0;
            c1_rvalid_q <= 1'b0;
            c0_rdata_q  <= 8'd0;
            c1_rdata_q  <= 8'd0;
            owner_q     <= 1'b1;
            burst_cnt_q <= 4'd0;
        end else begin
            gray_req_q  <= gray_req_d;
            gray_addr_q <= gray_addr_d;
            tag_q       <= tag_d;
            rv_pipe_q   <= rv_pipe_d;
            rtag_pipe_q <= rtag_pipe_d;
            c0_rvalid_q <= c0_rvalid_d;
            c1_rvalid_q <= c1_rvalid_d;
            c0_rdata_q  <= c0_rdata_d;
            c1_rdata_q  <= c1_rdata_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign bus.c0_gnt    = grant && !winner;
    assign bus.c1_gnt    = grant && winner;
    assign bus.c0_rvalid = c0_rvalid_q;
    assign bus.c1_rvalid = c1_rvalid_q;
    assign bus.c0_rdata  = c0_rdata_q;
    assign bus.c1_rdata  = c1_rdata_q;
    assign bus.gray_addr = gray_addr_q;
    assign bus.gray_req  = gray_req_q;
    assign bus.busy      = gray_req_q || rv_pipe_q || c0_rvalid_q || c1_rvalid_q;
endmodule

// File: tb/tb_gray_port_arbiter.sv
// tb/tb_gray_port_arbiter.sv - randomized and directed bench for gray_port_arbiter against a transaction model
module tb_gray_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gray_port_arbiter_if bus ();
    gray_port_arbiter #(.MAX_BURST(9)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    bit g0, g1;

    // Transaction-level model: one held memory request, one accepted read awaiting data,
    // one delivery per client, plus per-client queues of granted addresses for ordering.
    bit          m_req = 1'b0;
    logic [13:0] m_addr = 14'd0;
    int          m_tag = 0;
    bit          m_rv = 1'b0;
    int          m_rv_client = 0;
    logic [13:0] m_rv_addr = 14'd0;
    bit          m_rvalid0 = 1'b0, m_rvalid1 = 1'b0;
    logic [7:0]  m_rdata0 = 8'd0, m_rdata1 = 8'd0;
    int          m_owner = 1;
    int          m_run = 0;
    logic [13:0] q0[$];
    logic [13:0] q1[$];

    function automatic logic [7:0] hash(input logic [13:0] a);
        return a[7:0] ^ {a[13:8], 2'b01};
    endfunction

    function automatic logic [13:0] win_addr(input int idx);
        int a;
        a = 'h81 + (idx / 3 - 1) * 128 + (idx % 3 - 1);
        return 14'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        bit lk;
        if (!bus.c0_req && !bus.c1_req) return -1;
        if (bus.c0_req && !bus.c1_req) return 0;
        if (bus.c1_req && !bus.c0_req) return 1;
        lk = (m_owner == 0) ? bus.c0_lock : bus.c1_lock;
        if (lk && m_run < 9) return m_owner;
        return 1 - m_owner;
    endfunction

    task automatic drive(input bit r0, input logic [13:0] a0, input bit l0,
                         input bit r1, input logic [13:0] a1, input bit l1, input bit rdy);
        bus.c0_req = r0; bus.c0_addr = a0; bus.c0_lock = l0;
        bus.c1_req = r1; bus.c1_addr = a1; bus.c1_lock = l1;
        bus.gray_ready = rdy;
    endtask

    task automatic cycle();
        int w;
        bit acc;
        int acc_client;
        logic [13:0] acc_addr;
        #1;
        if (reset || (m_req && !bus.gray_ready)) w = -1;
        else w = pick();
        g0 = bus.c0_gnt;
        g1 = bus.c1_gnt;
        chk("c0_gnt", 32'(g0), 32'(w == 0));
        chk("c1_gnt", 32'(g1), 32'(w == 1));
        if (reset) begin
            m_req = 0; m_addr = 0; m_tag = 0; m_rv = 0;
            m_rvalid0 = 0; m_rvalid1 = 0; m_rdata0 = 0; m_rdata1 = 0;
            m_owner = 1; m_run = 0;
            q0.delete(); q1.delete();
        end else begin
            m_rvalid0 = m_rv && m_rv_client == 0;
            m_rvalid1 = m_rv && m_rv_client == 1;
            if (m_rvalid0 && q0.size() > 0) m_rdata0 = hash(q0.pop_front());
            if (m_rvalid1 && q1.size() > 0) m_rdata1 = hash(q1.pop_front());
            acc = m_req && bus.gray_ready;
            acc_client = m_tag;
            acc_addr = m_addr;
            if (w >= 0) begin
                m_req = 1;
                m_addr = (w == 0) ? bus.c0_addr : bus.c1_addr;
                m_tag = w;
                if (w == 0) q0.push_back(m_addr);
                else q1.push_back(m_addr);
                if (w == m_owner) m_run = (m_run < 15) ? m_run + 1 : 15;
                else begin
                    m_owner = w;
                    m_run = 1;
                end
            end else if (!m_req || bus.gray_ready) begin
                m_req = 0;
            end
            m_rv = acc;
            if (acc) begin
                m_rv_client = acc_client;
                m_rv_addr = acc_addr;
            end
        end
        @(posedge clk);
        #1;
        chk("gray_req", 32'(bus.gray_req), 32'(m_req));
        chk("gray_addr", 32'(bus.gray_addr), 32'(m_addr));
        chk("c0_rvalid", 32'(bus.c0_rvalid), 32'(m_rvalid0));
        chk("c1_rvalid", 32'(bus.c1_rvalid), 32'(m_rvalid1));
        chk("c0_rdata", 32'(bus.c0_rdata), 32'(m_rdata0));
        chk("c1_rdata", 32'(bus.c1_rdata), 32'(m_rdata1));
        chk("busy", 32'(bus.busy), 32'(m_req || m_rv || m_rvalid0 || m_rvalid1));
        bus.gray_data = m_rv ? hash(m_rv_addr) : 8'($urandom);
    endtask

    initial begin
        int n_c0, n_g, n_rv, n_rx, idx;
        bit done;
        bus.gray_data = 8'd0;
        drive(0, 14'd0, 0, 0, 14'd0, 0, 1);
        reset = 1'b1;
        cycle(); cycle();
        reset = 1'b0;

        // Single client read, 3-cycle latency
        drive(1, 14'h0081, 0, 0, 14'd0, 0, 1); cycle();
        chk("single_gnt", 32'(g0), 32'd1);
        drive(0, 14'd0, 0, 0, 14'd0, 0, 1);
        chk("single_addr", 32'(bus.gray_addr), 32'h81);
        cycle(); cycle();
        chk("single_rvalid", 32'(bus.c0_rvalid), 32'd1);
        chk("single_rdata", 32'(bus.c0_rdata), 32'(hash(14'h0081)));
        repeat (2) cycle();

        // Contention without lock
        repeat (8) begin
            drive(1, 14'($urandom), 0, 1, 14'($urandom), 0, 1); cycle();
        end

        // Burst lock: make c1 the owner, then c0 locks under contention
        drive(0, 14'd0, 0, 1, 14'($urandom), 0, 1); cycle();
        n_c0 = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            drive(1, 14'($urandom), 1, 1, 14'($urandom), 0, 1); cycle();
            if (g1) done = 1;
            else if (g0) n_c0++;
        end
        chk("burst_run", 32'(n_c0), 32'd9);
        chk("burst_then_c1", 32'(done), 32'd1);
        n_c0 = 0;
        repeat (20) begin
            drive(1, 14'($urandom), 1, 0, 14'd0, 0, 1); cycle();
            if (g0) n_c0++;
        end
        chk("lock_unlimited", 32'(n_c0), 32'd20);

        // Stall: memory not ready for 3 cycles while a request is held
        drive(0, 14'd0, 0, 0, 14'd0, 0, 1); repeat (3) cycle();
        drive(1, 14'h0100, 0, 0, 14'd0, 0, 1); cycle();
        n_g = 0;
        repeat (3) begin
            drive(1, 14'($urandom), 0, 1, 14'($urandom), 0, 0); cycle();
            n_g += int'(g0) + int'(g1);
            chk("stall_addr", 32'(bus.gray_addr), 32'h100);
        end
        chk("stall_gnts", 32'(n_g), 32'd0);
        drive(1, 14'($urandom), 0, 1, 14'($urandom), 0, 1); cycle();
        chk("stall_release_gnt", 32'(g0 | g1), 32'd1);
        drive(0, 14'd0, 0, 0, 14'd0, 0, 1); repeat (4) cycle();

        // Reset one cycle after a grant
        drive(0, 14'd0, 0, 1, 14'h0200, 0, 1); cycle();
        drive(0, 14'd0, 0, 0, 14'd0, 0, 1);
        reset = 1'b1; cycle(); reset = 1'b0;
        n_rv = 0;
        repeat (5) begin
            cycle();
            n_rv += int'(bus.c0_rvalid) + int'(bus.c1_rvalid);
        end
        chk("reset_no_rvalid", 32'(n_rv), 32'd0);
        drive(1, 14'h0300, 0, 0, 14'd0, 0, 1); cycle();
        drive(0, 14'd0, 0, 0, 14'd0, 0, 1); cycle(); cycle();
        chk("fresh_rvalid", 32'(bus.c0_rvalid), 32'd1);
        chk("fresh_rdata", 32'(bus.c0_rdata), 32'(hash(14'h0300)));
        repeat (2) cycle();

        // 3x3 window sweep under lock with c1 traffic
        idx = 0; n_rx = 0;
        for (int i = 0; i < 80 && n_rx < 9; i++) begin
            drive(idx < 9, win_addr(idx < 9 ? idx : 0), idx < 9,
                  (idx < 6) && 1'($urandom), 14'($urandom), 0, 1);
            cycle();
            if (g0) idx++;
            n_rx += int'(bus.c0_rvalid);
        end
        chk("window_rx", 32'(n_rx), 32'd9);
        drive(0, 14'd0, 0, 0, 14'd0, 0, 1); cycle();
        chk("window_busy_idle", 32'(bus.busy), 32'd0);

        // Randomized traffic with occasional reset
        repeat (400) begin
            reset = ($urandom % 100) == 0;
            drive(1'($urandom), 14'($urandom), ($urandom % 3) == 0,
                  1'($urandom), 14'($urandom), ($urandom % 3) == 0,
                  ($urandom % 4) != 0);
            cycle();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/gray_port_arbiter.md
# gray_port_arbiter

Shares the single gray-image memory read port (gray_addr/gray_req/gray_ready/gray_data) between two requesters, for example an LBP engine and a second window filter. Arbitration is round-robin with an optional burst lock, so an engine can finish its 3×3 window fetch without interruption. The block tags every accepted read and routes the returned pixel back to the requester that issued it. It sits between the engines and the gray memory. Neither engine drives the memory port directly.

## Interface
- MAX_BURST, 9: maximum consecutive grants a locking client may hold while the other client is requesting (1..15).
- clk  in  1: single clock, rising edge.
- reset  in  1: synchronous, active-high.
- c0_req, c1_req  in  1 each: read request, held until granted.
- c0_addr, c1_addr  in  14 each: pixel address, valid while the matching cN_req is high.
- c0_lock, c1_lock  in  1 each: request to keep ownership for the next grant (burst).
- c0_gnt, c1_gnt  out  1 each: combinational; request accepted this cycle. The client may change address or drop req next cycle.
- c0_rvalid, c1_rvalid  out  1 each: registered; one-cycle pulse when returned data is on cN_rdata.
- c0_rdata, c1_rdata  out  8 each: returned pixel, valid only with the matching cN_rvalid.
- gray_addr  out  14: registered memory address.
- gray_req  out  1: registered memory request.
- gray_ready  in  1: memory accepts the request in any cycle where gray_req && gray_ready.
- gray_data  in  8: valid in the cycle after acceptance.
- busy  out  1: gray_req, or any read in flight.

## Operation
- Output slot: gray_req/gray_addr form a one-deep holding register plus a tag register (owner ID).
  - slot_free = !gray_req || gray_ready.
  - A grant happens only when slot_free is true.
  - While gray_req && !gray_ready, the register holds gray_addr, gray_req and the tag unchanged, and both gnt outputs stay 0.
- Winner selection (combinational):
  - Only one client requesting: that client wins.
  - Both requesting: the owner (last granted client) wins if its lock is high and burst_cnt < MAX_BURST. Otherwise the non-owner wins (round-robin).
  - After reset, priority goes to client 0 (owner=1, burst_cnt=0).
- On a grant:
  - gray_addr <= winner addr, gray_req <= 1, tag <= winner.
  - If winner == owner, burst_cnt <= burst_cnt+1 (saturates at 15). Otherwise owner <= winner and burst_cnt <= 1.
- If there is no grant and the slot is free, gray_req <= 0 and gray_addr holds its value.
- Lock without contention is unlimited, because the burst limit applies only when both clients request.
- Return path:
  - Acceptance (gray_req && gray_ready) sets rv_pipe <= 1 and rtag_pipe <= tag. Otherwise rv_pipe <= 0.
  - In the next cycle gray_data is valid. cN_rvalid <= rv_pipe && (rtag_pipe==N), and cN_rdata <= gray_data for the matching client. The other client's rdata holds.
- Ordering: returns are delivered in grant order, and each client's returns arrive in its own request order.
- Reset mid-operation:
  - All in-flight reads are discarded.
  - No rvalid pulses appear after reset, even if gray_data changes.
  - Clients must reissue their requests.
- busy = gray_req || rv_pipe || any cN_rvalid.

## Timing
- Reset values:
  - gray_req=0, gray_addr=0, tag=0.
  - rv_pipe=0, c0/c1_rvalid=0, c0/c1_rdata=0.
  - owner=1, burst_cnt=0, busy=0.
  - gnt outputs are forced to 0 while reset is high.
- Latency, with gray_ready held high:
  - Cycle t: gnt.
  - Cycle t+1: gray_req and gray_addr presented and accepted.
  - Cycle t+2: gray_data valid.
  - Cycle t+3: cN_rvalid and cN_rdata.
  - Grant to data is 3 cycles.
- Throughput: one grant per cycle when gray_ready stays high. Back-to-back grants to alternating clients are allowed.
- Each cycle of gray_ready low while gray_req is high adds exactly one cycle of stall before the next grant. The return latency of the stalled request is counted from its acceptance cycle.
- Simultaneous events in one cycle (acceptance of the held request, a new grant and a return delivery) are all legal and independent.

## Test plan
- Single client: c0_req with addr 0x0081 at t, gray_data=0x5A at t+2 -> c0_gnt=1 at t; gray_addr=0x0081, gray_req=1 at t+1; c0_rvalid=1, c0_rdata=0x5A at t+3; c1_rvalid stays 0.
- Contention, no lock: both clients request continuously from reset -> grant order 0,1,0,1...; each return is routed to the client that issued it.
- Burst lock: MAX_BURST=9, both clients request, c0_lock=1 -> nine consecutive c0 grants, then c1 is granted; if c1 drops its request, c0 grants continue without limit.
- Stall: gray_ready low for 3 cycles while a request is held -> gray_addr and gray_req stable, no gnt pulses; the first grant comes in the cycle gray_ready returns high; data latency is counted from acceptance.
- Reset mid-flight: reset asserted one cycle after a grant -> no rvalid ever pulses for that read; all outputs at reset values the cycle after reset; a fresh request then completes with 3-cycle latency.
- Full-window sweep: client 0 issues the 9 addresses of a 3×3 window around 0x0081 under lock, interleaved with client 1 traffic -> client 0 receives its 9 pixels in order; busy returns to 0 exactly one cycle after the last rvalid.
